sub_sum_accum: RTL and testbench
================================

# sub_sum_accum

Downstream consumer of the `sub` stage's `as` (signed 4-bit) and `bs` (unsigned 4-bit) outputs.
- Per accepted sample it forms `as + bs` with correct signedness and accumulates NSAMP terms into a saturating signed sum.
- The finished sum is presented on a valid/ready output port.
- Sits between `sub` and the result-collection logic in `t`.

## Interface

Parameters:
- NSAMP, default 4: terms per result; legal range 1..255.
- ACC_W, default 10: accumulator/result width, signed; minimum 6.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear; aborts the current accumulation.
- in_valid  input  1  sample present on `as`/`bs`.
- in_ready  output  1  block can accept a sample.
- as  input  4  signed operand, from `sub.as`.
- bs  input  4  unsigned operand, from `sub.bs`.
- out_valid  output  1  `sum` holds a completed result.
- out_ready  input  1  downstream accepts the result.
- sum  output  ACC_W  signed accumulated result.
- sat  output  1  saturation occurred during this result.
- cnt  output  8  samples accepted in the current accumulation.

## Operation

Arithmetic:
- term = sign-extend(`as`) + zero-extend(`bs`), as 6-bit signed; range -8..+22.
- The next accumulator value is acc + sign-extend(term), computed one bit wider than ACC_W.
- That value is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Any clamp sets `sat`; `sat` is sticky until the result handoff.

States:
- ACC: `in_ready`=1, `out_valid`=0.
  - Accept when `in_valid`&`in_ready`: update acc, increment `cnt`.
  - Accepting the NSAMP-th sample moves to OUT.
- OUT: `in_ready`=0, `out_valid`=1. `sum`, `sat` and `cnt` (=NSAMP) are held stable.
  - When `out_ready`=1: clear acc, `sat` and `cnt`, then return to ACC.

Priority:
- `rst` is highest.
- `clr` is next. It forces ACC with acc=0, `cnt`=0, `sat`=0 in both states; any pending result is discarded without handoff.
- Normal handshakes come last.

Other rules:
- `sum` always shows the registered acc, including partial sums while in ACC.
- NSAMP=1: every accepted sample goes straight to OUT.

## Timing

Reset values: all outputs 0 except `in_ready`=1; state=ACC.
- `in_ready` and `out_valid` are decoded only from registered state; no combinational input-to-output path.
- Latency: `out_valid` rises on the clock edge that accepts the NSAMP-th sample, so it is visible in the next cycle.
- Handoff completes on the edge where `out_valid`&`out_ready`.
  - `in_ready` is 1 in the following cycle.
  - One bubble cycle per result.
- Throughput with `out_ready` held at 1 and `in_valid` held at 1: one result per NSAMP+1 cycles.
- Backpressure:
  - OUT may last indefinitely.
  - `in_valid` is ignored while `in_ready`=0.
  - No sample is dropped or double-counted.
- `clr` in the same cycle as an accept: the sample is discarded and acc=0.
- `clr` in the same cycle as an output handoff: the clear takes effect and the result counts as not consumed.
- Saturation boundary:
  - A sum landing exactly on a limit does not set `sat`.
  - Once clamped, later terms of opposite sign accumulate from the clamped value.
- `rst` asserted mid-accumulation or in OUT: immediate return to reset values with no clock edge needed; deassertion is synchronised externally.

## Test plan

- Default parameters, 4 accepts of `as`=3, `bs`=5 -> `out_valid`=1 in the cycle after the 4th accept, `sum`=32, `sat`=0, `cnt`=4.
- 4 accepts of `as`=4'b1000 (-8), `bs`=2 -> `sum`=-24 (10'h3E8), `sat`=0.
  - Confirms sign extension of `as` and zero extension of `bs`.
- ACC_W=6: 4 accepts of `as`=7, `bs`=15 (term 22) -> `sum`=31, `sat`=1.
- ACC_W=6, NSAMP=5: 5 accepts of `as`=-8, `bs`=0 -> `sum`=-32, `sat`=1.
- Hold `out_ready`=0 for 3 cycles in OUT with `in_valid`=1 -> `sum` stable, `in_ready`=0, no `cnt` change.
  - Then raise `out_ready` for 1 cycle -> next cycle `in_ready`=1, `sum`=0.
- After 2 accepts (`sum`=16), pulse `clr` together with a third valid sample -> `sum`=0, `cnt`=0, sample discarded.
  - Then assert `rst` while in OUT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sub_sum_accum.sv
// Accumulates NSAMP terms of (signed as + unsigned bs) into a saturating signed sum,
// then holds the result on a valid/ready port until it is taken (one bubble per result).
module sub_sum_accum #(
    parameter int NSAMP = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       as,
    input  logic [3:0]       bs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sat,
    output logic [7:0]       cnt
);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]       CNT_LAST = 8'(NSAMP - 1);

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [5:0]       term;
    logic [ACC_W:0]   acc_ext;
    logic             ovf;
    logic [ACC_W-1:0] acc_next;

    assign term    = {{2{as[3]}}, as} + {2'b00, bs};
    assign acc_ext = {acc[ACC_W-1], acc} + {{(ACC_W-5){term[5]}}, term};

    // The wide sum cannot wrap, so disagreeing top bits mean the narrow range was left.
    assign ovf = acc_ext[ACC_W] ^ acc_ext[ACC_W-1];

    always_comb begin
        acc_next = acc_ext[ACC_W-1:0];
        if (ovf) begin
            acc_next = acc_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_OUT);
    assign sum       = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
            acc   <= '0;
            sat   <= 1'b0;
            cnt   <= 8'd0;
        end else if (clr) begin
            state <= ST_ACC;
            acc   <= '0;
            sat   <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        sat <= sat | ovf;
                        cnt <= cnt + 8'd1;
                        if (cnt == CNT_LAST) begin
                            state <= ST_OUT;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= ST_ACC;
                        acc   <= '0;
                        sat   <= 1'b0;
                        cnt   <= 8'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_sum_accum.sv
// Directed bench for sub_sum_accum: three instances (default, ACC_W=6/NSAMP=5, ACC_W=6/NSAMP=1).
module tb_sub_sum_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv[3];
    logic       clr_v[3];
    logic       ordy[3];
    logic [3:0] as_v[3];
    logic [3:0] bs_v[3];
    logic       ir[3];
    logic       ov[3];
    logic       satv[3];
    logic [7:0] cntv[3];
    logic [9:0] sum_a;
    logic [5:0] sum_b;
    logic [5:0] sum_c;

    int total = 0;
    int bad   = 0;

    sub_sum_accum #(.NSAMP(4), .ACC_W(10)) dut_a (
        .clk(clk), .rst(rst), .clr(clr_v[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .as(as_v[0]), .bs(bs_v[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(sum_a), .sat(satv[0]), .cnt(cntv[0])
    );

    sub_sum_accum #(.NSAMP(5), .ACC_W(6)) dut_b (
        .clk(clk), .rst(rst), .clr(clr_v[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .as(as_v[1]), .bs(bs_v[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(sum_b), .sat(satv[1]), .cnt(cntv[1])
    );

    sub_sum_accum #(.NSAMP(1), .ACC_W(6)) dut_c (
        .clk(clk), .rst(rst), .clr(clr_v[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .as(as_v[2]), .bs(bs_v[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(sum_c), .sat(satv[2]), .cnt(cntv[2])
    );

    typedef struct {
        int          d;
        int          n;
        logic [19:0] a;
        logic [19:0] b;
        int          es;
        int          esat;
    } vec_t;

    vec_t tbl[11];

    function automatic int get_sum(input int d);
        if (d == 0) return int'($signed(sum_a));
        if (d == 1) return int'($signed(sum_b));
        return int'($signed(sum_c));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int d, input logic [3:0] a, input logic [3:0] b);
        iv[d]   = 1'b1;
        as_v[d] = a;
        bs_v[d] = b;
        tick();
        iv[d]   = 1'b0;
    endtask

    task automatic check_idle(input string tag, input int d);
        check({tag, " in_ready"}, int'(ir[d]), 1);
        check({tag, " out_valid"}, int'(ov[d]), 0);
        check({tag, " sum"}, get_sum(d), 0);
        check({tag, " sat"}, int'(satv[d]), 0);
        check({tag, " cnt"}, int'(cntv[d]), 0);
    endtask

    task automatic fill_a(input int k, input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < k; i++) accept(0, a, b);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; clr_v[i] = 1'b0; ordy[i] = 1'b0;
            as_v[i] = 4'd0; bs_v[i] = 4'd0;
        end

        tbl[0]  = '{0, 4, 20'h03333, 20'h05555,  32, 0};
        tbl[1]  = '{0, 4, 20'h08888, 20'h02222, -24, 0};
        tbl[2]  = '{0, 4, 20'h07777, 20'h0FFFF,  88, 0};
        tbl[3]  = '{0, 4, 20'h005EF, 20'h01000,   3, 0};
        tbl[4]  = '{1, 5, 20'h88888, 20'h00000, -32, 1};
        tbl[5]  = '{1, 5, 20'h77777, 20'hFFFFF,  31, 1};
        tbl[6]  = '{1, 5, 20'h08888, 20'h00000, -32, 0};
        tbl[7]  = '{1, 5, 20'h88877, 20'h000FF,   7, 1};
        tbl[8]  = '{1, 5, 20'h00017, 20'h0008F,  31, 0};
        tbl[9]  = '{2, 1, 20'h00008, 20'h0000F,   7, 0};
        tbl[10] = '{2, 1, 20'h00007, 20'h0000F,  22, 0};

        #12;
        for (int d = 0; d < 3; d++) check_idle("reset", d);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 11; v++) begin
            int d;
            d = tbl[v].d;
            check($sformatf("v%0d ready", v), int'(ir[d]), 1);
            for (int k = 0; k < tbl[v].n; k++) begin
                accept(d, tbl[v].a[4*k +: 4], tbl[v].b[4*k +: 4]);
            end
            check($sformatf("v%0d out_valid", v), int'(ov[d]), 1);
            check($sformatf("v%0d in_ready", v), int'(ir[d]), 0);
            check($sformatf("v%0d sum", v), get_sum(d), tbl[v].es);
            check($sformatf("v%0d sat", v), int'(satv[d]), tbl[v].esat);
            check($sformatf("v%0d cnt", v), int'(cntv[d]), tbl[v].n);
            ordy[d] = 1'b1;
            tick();
            ordy[d] = 1'b0;
            check_idle($sformatf("v%0d handoff", v), d);
        end

        // Backpressure: OUT held while in_valid keeps offering samples.
        fill_a(4, 4'd3, 4'd5);
        iv[0] = 1'b1; as_v[0] = 4'd1; bs_v[0] = 4'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp sum", get_sum(0), 32);
            check("bp in_ready", int'(ir[0]), 0);
            check("bp cnt", int'(cntv[0]), 4);
            check("bp out_valid", int'(ov[0]), 1);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check_idle("bp release", 0);

        // Clear together with an accept discards the sample.
        fill_a(2, 4'd3, 4'd5);
        check("pre-clr sum", get_sum(0), 16);
        check("pre-clr cnt", int'(cntv[0]), 2);
        iv[0] = 1'b1; as_v[0] = 4'd3; bs_v[0] = 4'd5; clr_v[0] = 1'b1;
        tick();
        iv[0] = 1'b0; clr_v[0] = 1'b0;
        check_idle("clr accept", 0);
        tick();
        check("clr hold sum", get_sum(0), 0);

        // Clear during an output handoff: result dropped, back to ACC.
        fill_a(4, 4'd3, 4'd5);
        ordy[0] = 1'b1; clr_v[0] = 1'b1;
        tick();
        ordy[0] = 1'b0; clr_v[0] = 1'b0;
        check_idle("clr handoff", 0);

        // Saturated result in B, then asynchronous reset while A and B sit in OUT.
        fill_a(4, 4'd7, 4'd15);
        for (int k = 0; k < 5; k++) accept(1, 4'd8, 4'd0);
        check("pre-rst ov_a", int'(ov[0]), 1);
        check("pre-rst sat_b", int'(satv[1]), 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async rst a", 0);
        check_idle("async rst b", 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle("post rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected finish before 50000");
        $fatal(1);
    end

endmodule
